pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 117 +++++++++++
 tb/tb_pipe_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - five-stage pipeline hazard controller with stall/flush FSM and event counters
module pipe_ctrl #(
    parameter int MAX_STALL = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_req,
    input  logic             flush_req,
    input  logic             pc_sel,
    input  logic             imem_ready,
    output logic             pc_en,
    output logic             pc_load,
    output logic             if_de_en,
    output logic             de_exe_en,
    output logic             exe_bubble,
    output logic             v_de,
    output logic             v_exe,
    output logic             v_acc,
    output logic             v_wb,
    output logic             stall_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Wide enough to hold MAX_STALL+1 so the watchdog threshold is reachable without wrap.
    localparam int CW = $clog2(MAX_STALL + 2);
    localparam logic [CW-1:0] CONSEC_LIM = CW'(MAX_STALL + 1);

    state_t           state_q;
    logic             v_de_q, v_exe_q, v_acc_q, v_wb_q;
    logic             stall_err_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic [CW-1:0]    consec_q;
    logic             take_flush, take_stall;

    // The cycle spent in FLUSH ignores both redirect requests.
    always_comb begin
        take_flush = rst && flush_req && (state_q != FLUSH);
        take_stall = rst && stall_req && !flush_req && (state_q != FLUSH);
    end

    always_comb begin
        pc_en      = 1'b0;
        pc_load    = 1'b0;
        if_de_en   = 1'b0;
        de_exe_en  = 1'b0;
        exe_bubble = 1'b0;
        if (rst) begin
            if (take_flush) begin
                pc_en     = 1'b1;
                pc_load   = 1'b1;
                if_de_en  = 1'b1;
                de_exe_en = 1'b1;
            end else if (take_stall) begin
                exe_bubble = 1'b1;
            end else begin
                pc_en     = imem_ready;
                pc_load   = imem_ready && pc_sel;
                if_de_en  = 1'b1;
                de_exe_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            v_de_q      <= 1'b0;
            v_exe_q     <= 1'b0;
            v_acc_q     <= 1'b0;
            v_wb_q      <= 1'b0;
            stall_err_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            consec_q    <= '0;
        end else begin
            v_acc_q <= v_exe_q;
            v_wb_q  <= v_acc_q;
            if (take_flush) begin
                state_q  <= FLUSH;
                v_de_q   <= 1'b0;
                v_exe_q  <= 1'b0;
                consec_q <= '0;
                if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end else if (take_stall) begin
                state_q <= STALL;
                v_exe_q <= 1'b0;
                if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                if (consec_q != CONSEC_LIM) consec_q <= consec_q + CW'(1);
                if (consec_q + CW'(1) == CONSEC_LIM) stall_err_q <= 1'b1;
            end else begin
                state_q  <= RUN;
                v_de_q   <= imem_ready;
                v_exe_q  <= v_de_q;
                consec_q <= '0;
            end
        end
    end

    assign v_de      = v_de_q;
    assign v_exe     = v_exe_q;
    assign v_acc     = v_acc_q;
    assign v_wb      = v_wb_q;
    assign stall_err = stall_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - vector table, corner sequences and randomized model check for pipe_ctrl
module tb_pipe_ctrl;

    localparam int MAX_STALL = 4;
    localparam int CNT_W     = 4;
    localparam int SAT       = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, stall_req, flush_req, pc_sel, imem_ready;
    logic pc_en, pc_load, if_de_en, de_exe_en, exe_bubble;
    logic v_de, v_exe, v_acc, v_wb, stall_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
        .pc_sel(pc_sel), .imem_ready(imem_ready), .pc_en(pc_en), .pc_load(pc_load),
        .if_de_en(if_de_en), .de_exe_en(de_exe_en), .exe_bubble(exe_bubble),
        .v_de(v_de), .v_exe(v_exe), .v_acc(v_acc), .v_wb(v_wb), .stall_err(stall_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
    );

    typedef struct {
        logic       rst, stall, flush, sel, imem;
        logic [4:0] ctl;   // {pc_en, pc_load, if_de_en, de_exe_en, exe_bubble} during the cycle
        logic [3:0] v;     // {v_de, v_exe, v_acc, v_wb} after the edge
        int         st, scnt, fcnt;
    } vec_t;

    vec_t tbl[$];

    // Reference model: pipeline as a list of slots, counts as plain integers.
    bit m_v[4];
    bit m_in_flush, m_err;
    int m_consec, m_sc, m_fc, m_st;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, s, f, sl, im, input logic [4:0] c,
                                input logic [3:0] v, input int st, sc, fc);
        vec_t x;
        x.rst = r; x.stall = s; x.flush = f; x.sel = sl; x.imem = im;
        x.ctl = c; x.v = v; x.st = st; x.scnt = sc; x.fcnt = fc;
        return x;
    endfunction

    task automatic drive(input logic r, s, f, sl, im);
        rst = r; stall_req = s; flush_req = f; pc_sel = sl; imem_ready = im;
    endtask

    function automatic logic [4:0] ctl_now();
        return {pc_en, pc_load, if_de_en, de_exe_en, exe_bubble};
    endfunction

    function automatic logic [3:0] v_now();
        return {v_de, v_exe, v_acc, v_wb};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_v[i] = 0;
        m_in_flush = 0; m_err = 0; m_consec = 0; m_sc = 0; m_fc = 0; m_st = 0;
    endtask

    // Returns expected control word for this cycle and advances the model by one edge.
    task automatic model_step(input logic r, s, f, sl, im, output logic [4:0] ctl);
        bit fl, stl;
        if (!r) begin
            ctl = 5'b00000;
            model_reset();
            return;
        end
        fl  = f && !m_in_flush;
        stl = s && !fl && !m_in_flush;
        if (fl)       ctl = 5'b11110;
        else if (stl) ctl = 5'b00001;
        else if (!im) ctl = 5'b00110;
        else if (sl)  ctl = 5'b11110;
        else          ctl = 5'b10110;
        m_v[3] = m_v[2];
        m_v[2] = m_v[1];
        if (fl)       begin m_v[1] = 0; m_v[0] = 0; end
        else if (stl) m_v[1] = 0;
        else          begin m_v[1] = m_v[0]; m_v[0] = im; end
        if (fl)  m_fc = (m_fc < SAT) ? m_fc + 1 : SAT;
        if (stl) m_sc = (m_sc < SAT) ? m_sc + 1 : SAT;
        m_consec = stl ? m_consec + 1 : 0;
        if (m_consec >= MAX_STALL + 1) m_err = 1;
        m_in_flush = fl;
        m_st = fl ? 2 : (stl ? 1 : 0);
    endtask

    initial begin
        logic [4:0] ectl;
        drive(0, 0, 0, 0, 1);

        //            rst st fl sel im  ctl       v        st sc fc
        tbl.push_back(mk(0, 0, 0, 0, 1, 5'b00000, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 5'b10110, 4'b1000, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 5'b10110, 4'b1100, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 5'b10110, 4'b1110, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 5'b10110, 4'b1111, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 5'b00001, 4'b1011, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 5'b00001, 4'b1001, 1, 2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 5'b10110, 4'b1100, 0, 2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 5'b10110, 4'b1110, 0, 2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 5'b10110, 4'b1111, 0, 2, 0));
        tbl.push_back(mk(1, 1, 1, 0, 1, 5'b11110, 4'b0011, 2, 2, 1));
        tbl.push_back(mk(1, 1, 1, 0, 1, 5'b10110, 4'b1001, 0, 2, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 5'b00110, 4'b0100, 0, 2, 1));
        tbl.push_back(mk(1, 0, 0, 1, 1, 5'b11110, 4'b1010, 0, 2, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 5'b00110, 4'b0101, 0, 2, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 5'b00000, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 5'b00001, 4'b0000, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 5'b00000, 4'b0000, 0, 0, 0));

        #1;
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].sel, tbl[i].imem);
            #1;
            chk($sformatf("vec%0d ctl", i), ctl_now(), tbl[i].ctl);
            @(posedge clk); #1;
            chk($sformatf("vec%0d valid", i), v_now(), tbl[i].v);
            chk($sformatf("vec%0d state", i), state, tbl[i].st);
            chk($sformatf("vec%0d stall_cnt", i), stall_cnt, tbl[i].scnt);
            chk($sformatf("vec%0d flush_cnt", i), flush_cnt, tbl[i].fcnt);
        end

        // Watchdog: six consecutive stalls, flag rises on the fifth and is sticky.
        drive(1, 1, 0, 0, 1);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("stall_err after stall %0d", k), stall_err, (k >= MAX_STALL + 1) ? 1 : 0);
            chk($sformatf("state during stall %0d", k), state, 1);
        end
        drive(1, 0, 0, 0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_err sticky", stall_err, 1);
        chk("stall_cnt after 6", stall_cnt, 6);
        drive(1, 1, 0, 0, 1);
        #1;
        chk("stall honoured after err", exe_bubble, 1);

        // Saturation: 2^CNT_W stalls must pin the counter at all-ones.
        repeat (1 << CNT_W) @(posedge clk);
        #1;
        chk("stall_cnt saturated", stall_cnt, SAT);
        @(posedge clk); #1;
        chk("stall_cnt still saturated", stall_cnt, SAT);
        drive(0, 1, 0, 0, 1);
        @(posedge clk); #1;
        chk("stall_cnt after reset", stall_cnt, 0);
        chk("stall_err after reset", stall_err, 0);
        chk("state after reset", state, 0);

        // Randomized run against the reference model.
        model_reset();
        for (int n = 0; n < 600; n++) begin
            logic r, s, f, sl, im;
            r  = ($urandom_range(0, 39) != 0);
            s  = ($urandom_range(0, 2) == 0);
            f  = ($urandom_range(0, 5) == 0);
            sl = $urandom_range(0, 1);
            im = ($urandom_range(0, 4) != 0);
            drive(r, s, f, sl, im);
            model_step(r, s, f, sl, im, ectl);
            #1;
            chk("rand ctl", ctl_now(), ectl);
            @(posedge clk); #1;
            chk("rand valid", v_now(), {m_v[0], m_v[1], m_v[2], m_v[3]});
            chk("rand state", state, m_st);
            chk("rand stall_cnt", stall_cnt, m_sc);
            chk("rand flush_cnt", flush_cnt, m_fc);
            chk("rand stall_err", stall_err, m_err);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
